if_fetch: RTL and testbench

- Instruction-fetch stage feeding the decode stage's pc/inst inputs through the IF/ID path.
- Holds the PC and reads one 32-bit instruction as four little-endian byte reads over an 8-bit memory port.
- Offers the instruction to the downstream stage with a valid/ready handshake.
- Accepts a PC redirect from branch/jump resolution, which aborts any fetch in progress.

---
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: assembles one 32-bit little-endian instruction from four
// byte reads and offers it downstream with valid/ready; redirects restart fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        misalign_o
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][7:0] lanes_q, lanes_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     pco_q, pco_d;
  logic            mis_q, mis_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      idx_q   <= 2'd0;
      lanes_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      pco_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    mis_d   = 1'b0;

    if (redirect_i) begin
      // Any ack this cycle and any partial lanes are dropped with the old fetch.
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      idx_d   = 2'd0;
      state_d = FETCH;
      valid_d = 1'b0;
      req_d   = 1'b1;
      addr_d  = {redirect_pc_i[31:2], 2'b00};
      mis_d   = |redirect_pc_i[1:0];
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && mem_ack_i) begin
            if (idx_q == 2'd3) begin
              state_d = HOLD;
              valid_d = 1'b1;
              inst_d  = {mem_rdata_i, lanes_q[2], lanes_q[1], lanes_q[0]};
              pco_d   = pc_q;
              req_d   = 1'b0;
              pc_d    = pc_q + 32'd4;
              idx_d   = 2'd0;
            end else begin
              case (idx_q)
                2'd0:    lanes_d[0] = mem_rdata_i;
                2'd1:    lanes_d[1] = mem_rdata_i;
                default: lanes_d[2] = mem_rdata_i;
              endcase
              idx_d  = idx_q + 2'd1;
              req_d  = 1'b1;
              addr_d = pc_q + 32'(idx_q) + 32'd1;
            end
          end else begin
            // Also covers the first cycle out of reset, when no request is up yet.
            req_d  = 1'b1;
            addr_d = pc_q + 32'(idx_q);
          end
        end
        HOLD: begin
          if (valid_q && inst_ready_i) begin
            valid_d = 1'b0;
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pco_q;
  assign misalign_o   = mis_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios plus randomized ack/ready/redirect
// traffic checked against an in-order expected-PC scoreboard.
module tb_if_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RESET_PC = 0
  logic        rst, req, ack, redir, ready, valid, mis;
  logic [31:0] addr, redir_pc, pc, inst;
  logic [7:0]  rdata;
  logic        force_en;
  logic [7:0]  force_val;

  // wrap instance, RESET_PC = 0xFFFF_FFFC
  logic        rst_b, req_b, ack_b, redir_b, ready_b, valid_b, mis_b;
  logic [31:0] addr_b, redir_pc_b, pc_b, inst_b;
  logic [7:0]  rdata_b;

  int          nchk, npass, n_hs;
  logic [31:0] exp_pc;
  int          wait_n, wcnt;
  bit          rand_wait;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  assign rdata   = force_en ? force_val : byte_at(addr);
  assign rdata_b = byte_at(addr_b);

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .mem_req_o(req), .mem_addr_o(addr), .mem_rdata_i(rdata),
    .mem_ack_i(ack), .redirect_i(redir), .redirect_pc_i(redir_pc),
    .inst_valid_o(valid), .inst_ready_i(ready), .pc_o(pc), .inst_o(inst),
    .misalign_o(mis));

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_w (
    .clk(clk), .rst(rst_b), .mem_req_o(req_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b),
    .mem_ack_i(ack_b), .redirect_i(redir_b), .redirect_pc_i(redir_pc_b),
    .inst_valid_o(valid_b), .inst_ready_i(ready_b), .pc_o(pc_b), .inst_o(inst_b),
    .misalign_o(mis_b));

  // Advance one cycle: score the handshake about to complete, then drive ack
  // for the new cycle from the wait-state policy.
  task automatic step();
    if (valid && ready) begin
      nchk++;
      if (pc === exp_pc && inst === word_at(exp_pc)) npass++;
      else $display("FAIL handshake: pc=%h inst=%h, expected pc=%h inst=%h",
                    pc, inst, exp_pc, word_at(exp_pc));
      exp_pc += 32'd4;
      n_hs++;
    end
    if (redir) exp_pc = {redir_pc[31:2], 2'b00};
    @(negedge clk);
    if (req) begin
      if (wcnt >= wait_n) begin
        ack = 1'b1; wcnt = 0;
        if (rand_wait) wait_n = $urandom_range(0, 3);
      end else begin
        ack = 1'b0; wcnt++;
      end
    end else begin
      ack = 1'b0; wcnt = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ready = 1'b1; redir = 1'b0; redir_pc = 32'd0; ack = 1'b0;
    force_en = 1'b0; force_val = 8'd0; wait_n = 0; wcnt = 0; rand_wait = 1'b0;
    exp_pc = 32'd0; n_hs = 0;
    repeat (2) @(negedge clk);
    nchk++;
    if ({req, addr, valid, pc, inst, mis} === '0) npass++;
    else $display("FAIL reset_outputs: req=%b addr=%h valid=%b pc=%h inst=%h mis=%b, expected all 0",
                  req, addr, valid, pc, inst, mis);
    rst = 1'b1;
    step();
    nchk++;
    if (req === 1'b1 && addr === 32'd0) npass++;
    else $display("FAIL first_request: req=%b addr=%h, expected 1/00000000", req, addr);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (req === 1'b1 && addr === 32'(i) && valid === 1'b0) npass++;
      else $display("FAIL basic_addr%0d: req=%b addr=%h valid=%b, expected 1/%h/0", i, req, addr, valid, i);
      step();
    end
    nchk++;
    if (valid === 1'b1 && inst === 32'h0010_0093 && pc === 32'd0 && req === 1'b0) npass++;
    else $display("FAIL basic_deliver: valid=%b inst=%h pc=%h req=%b, expected 1/00100093/0/0",
                  valid, inst, pc, req);
    step();
    nchk++;
    if (valid === 1'b0 && req === 1'b1 && addr === 32'd4) npass++;
    else $display("FAIL basic_next: valid=%b req=%b addr=%h, expected 0/1/4", valid, req, addr);
  endtask

  task automatic test_wait();
    redir = 1'b1; redir_pc = 32'd0; wait_n = 2;
    step();
    redir = 1'b0;
    for (int t = 0; t < 12; t++) begin
      nchk++;
      if (req === 1'b1 && addr === 32'(t / 3) && valid === 1'b0) npass++;
      else $display("FAIL wait_c%0d: req=%b addr=%h valid=%b, expected 1/%h/0", t, req, addr, valid, t / 3);
      step();
    end
    nchk++;
    if (valid === 1'b1 && inst === 32'h0010_0093 && pc === 32'd0) npass++;
    else $display("FAIL wait_deliver: valid=%b inst=%h pc=%h, expected 1/00100093/0", valid, inst, pc);
    wait_n = 0;
  endtask

  task automatic test_stall();
    ready = 1'b0; redir = 1'b1; redir_pc = 32'd0;
    step();
    redir = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (valid === 1'b1 && inst === 32'h0010_0093 && pc === 32'd0 && req === 1'b0) npass++;
      else $display("FAIL stall_c%0d: valid=%b inst=%h pc=%h req=%b, expected 1/00100093/0/0",
                    k, valid, inst, pc, req);
      step();
    end
    ready = 1'b1;
    nchk++;
    if (valid === 1'b1 && req === 1'b0) npass++;
    else $display("FAIL stall_release: valid=%b req=%b, expected 1/0", valid, req);
    step();
    nchk++;
    if (valid === 1'b0 && req === 1'b1 && addr === 32'd4) npass++;
    else $display("FAIL stall_next: valid=%b req=%b addr=%h, expected 0/1/4", valid, req, addr);
  endtask

  task automatic test_redirect();
    step();
    step();
    nchk++;
    if (req === 1'b1 && addr === 32'd6) npass++;
    else $display("FAIL redir_pre: req=%b addr=%h, expected 1/6", req, addr);
    redir = 1'b1; redir_pc = 32'h100; force_en = 1'b1; force_val = 8'hAA; ack = 1'b1;
    step();
    redir = 1'b0; force_en = 1'b0;
    nchk++;
    if (req === 1'b1 && addr === 32'h100 && valid === 1'b0 && mis === 1'b0) npass++;
    else $display("FAIL redir_target: req=%b addr=%h valid=%b mis=%b, expected 1/100/0/0",
                  req, addr, valid, mis);
    repeat (4) step();
    nchk++;
    if (valid === 1'b1 && pc === 32'h100 && inst === word_at(32'h100)) npass++;
    else $display("FAIL redir_deliver: valid=%b pc=%h inst=%h, expected 1/100/%h",
                  valid, pc, inst, word_at(32'h100));
  endtask

  task automatic test_misalign();
    redir = 1'b1; redir_pc = 32'h102;
    step();
    redir = 1'b0;
    nchk++;
    if (mis === 1'b1 && req === 1'b1 && addr === 32'h100) npass++;
    else $display("FAIL misalign_pulse: mis=%b req=%b addr=%h, expected 1/1/100", mis, req, addr);
    step();
    nchk++;
    if (mis === 1'b0 && addr === 32'h101) npass++;
    else $display("FAIL misalign_clear: mis=%b addr=%h, expected 0/101", mis, addr);
    redir = 1'b1; redir_pc = 32'h200;
    step();
    redir_pc = 32'h303;
    nchk++;
    if (mis === 1'b0 && addr === 32'h200) npass++;
    else $display("FAIL double_first: mis=%b addr=%h, expected 0/200", mis, addr);
    step();
    redir = 1'b0;
    nchk++;
    if (mis === 1'b1 && addr === 32'h300 && req === 1'b1) npass++;
    else $display("FAIL double_last: mis=%b addr=%h req=%b, expected 1/300/1", mis, addr, req);
    step();
    nchk++;
    if (mis === 1'b0) npass++;
    else $display("FAIL double_clear: mis=%b, expected 0", mis);
    repeat (8) step();
  endtask

  task automatic test_random();
    int          hs0;
    bit          hold, exp_mis;
    logic [31:0] ppc, pinst;
    hs0 = n_hs;
    rand_wait = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) begin
        redir = 1'b1; redir_pc = $urandom;
      end else begin
        redir = 1'b0;
      end
      hold    = valid && !ready && !redir;
      exp_mis = redir && (redir_pc[1:0] != 2'b00);
      ppc     = pc;
      pinst   = inst;
      step();
      nchk++;
      if (mis === exp_mis) npass++;
      else $display("FAIL rand_misalign n=%0d: mis=%b, expected %b", n, mis, exp_mis);
      if (hold) begin
        nchk++;
        if (valid === 1'b1 && pc === ppc && inst === pinst && req === 1'b0) npass++;
        else $display("FAIL rand_hold n=%0d: valid=%b pc=%h inst=%h req=%b, expected 1/%h/%h/0",
                      n, valid, pc, inst, req, ppc, pinst);
      end
    end
    redir = 1'b0; ready = 1'b1; rand_wait = 1'b0; wait_n = 0;
    repeat (10) step();
    nchk++;
    if (n_hs - hs0 >= 20) npass++;
    else $display("FAIL rand_progress: handshakes=%0d, expected at least 20", n_hs - hs0);
  endtask

  task automatic test_wrap();
    int          got, c;
    logic [31:0] wexp;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    nchk++;
    if (req_b === 1'b1 && addr_b === 32'hFFFF_FFFC) npass++;
    else $display("FAIL wrap_first: req=%b addr=%h, expected 1/fffffffc", req_b, addr_b);
    got = 0; wexp = 32'hFFFF_FFFC;
    for (int k = 0; k < 40 && got < 2; k++) begin
      @(negedge clk);
      if (valid_b) begin
        nchk++;
        if (pc_b === wexp && inst_b === word_at(wexp)) npass++;
        else $display("FAIL wrap_deliver%0d: pc=%h inst=%h, expected %h/%h",
                      got, pc_b, inst_b, wexp, word_at(wexp));
        wexp += 32'd4; got++;
      end
    end
    nchk++;
    if (got == 2) npass++;
    else $display("FAIL wrap_timeout: deliveries=%0d, expected 2", got);
    c = 0;
    while (!(req_b === 1'b1 && addr_b === 32'd5) && c < 20) begin
      @(negedge clk); c++;
    end
    nchk++;
    if (c < 20) npass++;
    else $display("FAIL wrap_midfetch_timeout: addr=%h, expected 00000005", addr_b);
    rst_b = 1'b0;
    #1;
    nchk++;
    if ({req_b, addr_b, valid_b, pc_b, inst_b, mis_b} === '0) npass++;
    else $display("FAIL wrap_async_reset: req=%b addr=%h valid=%b pc=%h inst=%h mis=%b, expected all 0",
                  req_b, addr_b, valid_b, pc_b, inst_b, mis_b);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    nchk++;
    if (req_b === 1'b1 && addr_b === 32'hFFFF_FFFC) npass++;
    else $display("FAIL wrap_restart: req=%b addr=%h, expected 1/fffffffc", req_b, addr_b);
    repeat (4) @(negedge clk);
    nchk++;
    if (valid_b === 1'b1 && pc_b === 32'hFFFF_FFFC && inst_b === word_at(32'hFFFF_FFFC)) npass++;
    else $display("FAIL wrap_redeliver: valid=%b pc=%h inst=%h, expected 1/fffffffc/%h",
                  valid_b, pc_b, inst_b, word_at(32'hFFFF_FFFC));
  endtask

  initial begin
    nchk = 0; npass = 0;
    rst_b = 1'b0; ack_b = 1'b1; ready_b = 1'b1; redir_b = 1'b0; redir_pc_b = 32'd0;
    test_reset();
    test_basic();
    test_wait();
    test_stall();
    test_redirect();
    test_misalign();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
